result_stream_reader: RTL and testbench

Reads the 3x3 product matrix back out of the result memory after the multiplier signals done, and streams the elements in row-major order over a valid/ready output port. It sits between the result memory's read port and any downstream consumer (UART bridge, debug capture, next stage). It is the reader counterpart to the multiplier's write-side sequencing. A 2-entry output buffer with read-credit tracking absorbs the memory's one-cycle read latency under arbitrary backpressure.

---
 rtl/result_stream_reader.sv | 186 ++++++++++++++++++
 tb/tb_result_stream_reader.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_stream_reader.sv
// result_stream_reader
// Streams the DEPTH-element product matrix out of the result memory in
// row-major order over a valid/ready port. The memory has a one-cycle read
// latency. A 2-entry output buffer with read-credit accounting absorbs that
// latency under any amount of consumer backpressure.
module result_stream_reader #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 9,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_index,
    output logic              m_last
);

    // One extra bit lets the pointer reach DEPTH even when DEPTH == 2**ADDR_W.
    localparam int PTR_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;

    // Read issued last cycle; its data lands on mem_data this cycle.
    logic                inflight_q;
    logic [ADDR_W-1:0]   inflight_idx_q;

    // Output buffer: entry 0 is always the head.
    logic [1:0]          count_q, count_d;
    logic [DATA_W-1:0]   data0_q, data0_d, data1_q, data1_d;
    logic [ADDR_W-1:0]   idx0_q, idx0_d, idx1_q, idx1_d;

    logic                push;
    logic                pop;
    logic [2:0]          occupancy;
    logic                credit_ok;
    logic                issue;
    logic                reads_done;
    logic                last_pop;

    assign push = inflight_q;
    assign pop  = m_valid && m_ready;

    // Entries already committed (buffered plus in flight), minus the one leaving
    // this cycle. pop implies count_q >= 1, so the subtraction cannot underflow.
    assign occupancy  = {1'b0, count_q} + {2'b00, inflight_q};
    assign credit_ok  = (occupancy - {2'b00, pop}) < 3'd2;

    assign issue      = (state_q == RUN) && (rd_ptr_q < PTR_W'(DEPTH)) && credit_ok;
    assign reads_done = (rd_ptr_q == PTR_W'(DEPTH));

    // The final element leaves: nothing more to issue, nothing in flight,
    // and the head is the only buffered entry.
    assign last_pop   = reads_done && !inflight_q && (count_q == 2'd1) && pop;

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign mem_re   = issue;
    assign mem_addr = issue ? rd_ptr_q[ADDR_W-1:0] : '0;

    assign m_valid  = (count_q != 2'd0);
    assign m_data   = data0_q;
    assign m_index  = idx0_q;
    assign m_last   = (idx0_q == ADDR_W'(DEPTH - 1));

    // Next-state logic for the run sequencer and the read pointer.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    rd_ptr_d = '0;
                end
            end
            RUN: begin
                if (issue) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                if (last_pop) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next-state logic for the output buffer: push from memory, pop to consumer.
    always_comb begin
        count_d = count_q;
        data0_d = data0_q;
        data1_d = data1_q;
        idx0_d  = idx0_q;
        idx1_d  = idx1_q;
        unique case ({push, pop})
            2'b10: begin
                count_d = count_q + 2'd1;
                if (count_q == 2'd0) begin
                    data0_d = mem_data;
                    idx0_d  = inflight_idx_q;
                end else begin
                    data1_d = mem_data;
                    idx1_d  = inflight_idx_q;
                end
            end
            2'b01: begin
                count_d = count_q - 2'd1;
                data0_d = data1_q;
                idx0_d  = idx1_q;
            end
            2'b11: begin
                // Count unchanged; the new word goes behind whatever remains.
                if (count_q == 2'd1) begin
                    data0_d = mem_data;
                    idx0_d  = inflight_idx_q;
                end else begin
                    data0_d = data1_q;
                    idx0_d  = idx1_q;
                    data1_d = mem_data;
                    idx1_d  = inflight_idx_q;
                end
            end
            default: begin
            end
        endcase
    end

    // Sequencer state, read pointer and in-flight tracking.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q        <= IDLE;
            rd_ptr_q       <= '0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= '0;
        end else begin
            state_q        <= state_d;
            rd_ptr_q       <= rd_ptr_d;
            inflight_q     <= issue;
            inflight_idx_q <= issue ? rd_ptr_q[ADDR_W-1:0] : inflight_idx_q;
        end
    end

    // Output buffer storage and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the two buffer entries are reset (unlike a RAM) because they
        // drive m_data/m_index directly and must read zero out of reset.
        if (rst) begin
            count_q <= 2'd0;
            data0_q <= '0;
            data1_q <= '0;
            idx0_q  <= '0;
            idx1_q  <= '0;
        end else begin
            count_q <= count_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            idx0_q  <= idx0_d;
            idx1_q  <= idx1_d;
        end
    end

endmodule

// File: tb/tb_result_stream_reader.sv
// Directed bench for result_stream_reader: a registered-read memory model
// preloaded with the product of A=[1..9] and B=[9..1], a DEPTH=9 instance
// and a DEPTH=4 instance. Cycle c means the period after edge E(c-1), where
// E0 is the edge that samples start.
module tb_result_stream_reader;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              start, start_4;
    logic              m_ready, m_ready_4;
    logic [DATA_W-1:0] mem_data, mem_data_4;

    logic              busy, done, mem_re, m_valid, m_last;
    logic [ADDR_W-1:0] mem_addr, m_index;
    logic [DATA_W-1:0] m_data;

    logic              busy_4, done_4, mem_re_4, m_valid_4, m_last_4;
    logic [ADDR_W-1:0] mem_addr_4, m_index_4;
    logic [DATA_W-1:0] m_data_4;

    result_stream_reader #(.DATA_W(DATA_W), .DEPTH(9), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_data(mem_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_index(m_index), .m_last(m_last)
    );

    result_stream_reader #(.DATA_W(DATA_W), .DEPTH(4), .ADDR_W(ADDR_W)) dut_4 (
        .clk(clk), .rst(rst), .start(start_4), .busy(busy_4), .done(done_4),
        .mem_addr(mem_addr_4), .mem_re(mem_re_4), .mem_data(mem_data_4),
        .m_valid(m_valid_4), .m_ready(m_ready_4), .m_data(m_data_4),
        .m_index(m_index_4), .m_last(m_last_4)
    );

    // Hand-computed C = A*B, row-major.
    logic [DATA_W-1:0] exp_c [0:8] = '{16'd30, 16'd24, 16'd18, 16'd84, 16'd69,
                                       16'd54, 16'd138, 16'd114, 16'd90};
    logic [DATA_W-1:0] mem [0:15];

    // Result memory: one-cycle registered read.
    always @(posedge clk) begin
        if (mem_re)   mem_data   <= mem[mem_addr];
        if (mem_re_4) mem_data_4 <= mem[mem_addr_4];
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Observation log filled by collect().
    logic [DATA_W-1:0] hs_data [0:63];
    logic [ADDR_W-1:0] hs_idx  [0:63];
    logic              hs_last [0:63];
    int                hs_cyc  [0:63];
    logic [ADDR_W-1:0] iss_addr[0:63];
    int                iss_cyc [0:63];
    logic              busy_log[0:63];
    int n_hs, n_done, done_cyc, n_iss, stall_bad, first_vld;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one edge; returns in cycle 1.
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs cycles 1..ncyc of the main instance, driving m_ready (and start in
    // mode 3) and recording handshakes, issues, done and stall stability.
    // mode 0: ready=1; 1: ready on odd cycles; 2: ready=0 through cycle 10;
    // 3: ready=1 with extra start pulses in cycles 5 and 12.
    task automatic collect(input int mode, input int ncyc);
        logic              prev_stall;
        logic [DATA_W-1:0] pd;
        logic [ADDR_W-1:0] pi;
        logic              pl;
        n_hs = 0; n_done = 0; done_cyc = -1; n_iss = 0; stall_bad = 0;
        first_vld = -1; prev_stall = 1'b0; pd = '0; pi = '0; pl = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            case (mode)
                1:       m_ready = (c % 2 == 1);
                2:       m_ready = (c > 10);
                3: begin
                    m_ready = 1'b1;
                    start   = (c == 5 || c == 12);
                end
                default: m_ready = 1'b1;
            endcase
            @(negedge clk);
            if (prev_stall && (!m_valid || m_data !== pd || m_index !== pi || m_last !== pl))
                stall_bad++;
            if (m_valid && first_vld < 0) first_vld = c;
            if (m_valid && m_ready) begin
                hs_data[n_hs] = m_data;
                hs_idx[n_hs]  = m_index;
                hs_last[n_hs] = m_last;
                hs_cyc[n_hs]  = c;
                n_hs++;
            end
            if (done) begin
                n_done++;
                done_cyc = c;
            end
            if (mem_re) begin
                iss_addr[n_iss] = mem_addr;
                iss_cyc[n_iss]  = c;
                n_iss++;
            end
            busy_log[c] = busy;
            prev_stall = m_valid && !m_ready;
            pd = m_data; pi = m_index; pl = m_last;
            tick();
        end
        start   = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_4 = 1'b0; m_ready = 1'b0; m_ready_4 = 1'b0;
        #3;
        n_cmp++; if ({busy, done, mem_re, m_valid, m_last} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, mem_re, m_valid, m_last});
        end
        n_cmp++; if (mem_addr !== 4'd0 || m_index !== 4'd0) begin
            n_bad++; $display("FAIL reset_addr_index: got %0d/%0d expected 0/0", mem_addr, m_index);
        end
        n_cmp++; if (m_data !== 16'd0) begin
            n_bad++; $display("FAIL reset_data: got %0d expected 0", m_data);
        end
        n_cmp++; if ({busy_4, done_4, mem_re_4, m_valid_4} !== 4'b0) begin
            n_bad++; $display("FAIL reset_flags_d4: got %b expected 0000", {busy_4, done_4, mem_re_4, m_valid_4});
        end
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        do_start();
        collect(0, 14);
        n_cmp++; if (n_hs !== 9) begin
            n_bad++; $display("FAIL stream_count: got %0d expected 9", n_hs);
        end
        for (int i = 0; i < 9 && i < n_hs; i++) begin
            n_cmp++; if (hs_data[i] !== exp_c[i] || hs_idx[i] !== 4'(i) ||
                         hs_last[i] !== (i == 8) || hs_cyc[i] !== 3 + i) begin
                n_bad++; $display("FAIL stream_elem[%0d]: got data %0d idx %0d last %0d cyc %0d expected %0d %0d %0d %0d",
                                  i, hs_data[i], hs_idx[i], hs_last[i], hs_cyc[i], exp_c[i], i, (i == 8), 3 + i);
            end
        end
        n_cmp++; if (n_done !== 1 || done_cyc !== 12) begin
            n_bad++; $display("FAIL stream_done: got %0d pulses at cycle %0d expected 1 at 12", n_done, done_cyc);
        end
        for (int c = 1; c <= 14; c++) begin
            n_cmp++; if (busy_log[c] !== (c >= 1 && c <= 11)) begin
                n_bad++; $display("FAIL stream_busy[c%0d]: got %0d expected %0d", c, busy_log[c], (c <= 11));
            end
        end
    endtask

    task automatic test_toggle_ready();
        do_start();
        collect(1, 24);
        n_cmp++; if (n_hs !== 9) begin
            n_bad++; $display("FAIL toggle_count: got %0d expected 9", n_hs);
        end
        for (int i = 0; i < 9 && i < n_hs; i++) begin
            n_cmp++; if (hs_data[i] !== exp_c[i] || hs_idx[i] !== 4'(i) || hs_cyc[i] !== 3 + 2 * i) begin
                n_bad++; $display("FAIL toggle_elem[%0d]: got data %0d idx %0d cyc %0d expected %0d %0d %0d",
                                  i, hs_data[i], hs_idx[i], hs_cyc[i], exp_c[i], i, 3 + 2 * i);
            end
        end
        n_cmp++; if (stall_bad !== 0) begin
            n_bad++; $display("FAIL toggle_stable: got %0d unstable stalls expected 0", stall_bad);
        end
        n_cmp++; if (n_done !== 1 || done_cyc !== 20) begin
            n_bad++; $display("FAIL toggle_done: got %0d pulses at cycle %0d expected 1 at 20", n_done, done_cyc);
        end
    endtask

    task automatic test_stall();
        do_start();
        collect(2, 24);
        n_cmp++; if (n_iss < 3 || iss_addr[0] !== 4'd0 || iss_addr[1] !== 4'd1 ||
                     iss_cyc[0] !== 1 || iss_cyc[1] !== 2 || iss_cyc[2] !== 11) begin
            n_bad++; $display("FAIL stall_issues: got %0d issues, addr %0d,%0d at cycles %0d,%0d,%0d expected addr 0,1 at 1,2 then 11",
                              n_iss, iss_addr[0], iss_addr[1], iss_cyc[0], iss_cyc[1], iss_cyc[2]);
        end
        n_cmp++; if (first_vld !== 3 || stall_bad !== 0) begin
            n_bad++; $display("FAIL stall_hold: got first valid %0d, %0d unstable stalls expected 3, 0", first_vld, stall_bad);
        end
        n_cmp++; if (n_hs !== 9 || hs_cyc[0] !== 11 || hs_data[0] !== 16'd30 || hs_idx[0] !== 4'd0) begin
            n_bad++; $display("FAIL stall_first: got %0d elems, first %0d idx %0d cyc %0d expected 9, 30 idx 0 cyc 11",
                              n_hs, hs_data[0], hs_idx[0], hs_cyc[0]);
        end
        for (int i = 0; i < 9 && i < n_hs; i++) begin
            n_cmp++; if (hs_data[i] !== exp_c[i] || hs_cyc[i] !== 11 + i) begin
                n_bad++; $display("FAIL stall_elem[%0d]: got %0d at cyc %0d expected %0d at %0d",
                                  i, hs_data[i], hs_cyc[i], exp_c[i], 11 + i);
            end
        end
        n_cmp++; if (n_done !== 1 || done_cyc !== 20) begin
            n_bad++; $display("FAIL stall_done: got %0d pulses at cycle %0d expected 1 at 20", n_done, done_cyc);
        end
    endtask

    task automatic test_start_ignored();
        do_start();
        collect(3, 20);
        n_cmp++; if (n_hs !== 9 || n_done !== 1 || done_cyc !== 12) begin
            n_bad++; $display("FAIL restart_ignored: got %0d elems, %0d done at %0d expected 9, 1 at 12", n_hs, n_done, done_cyc);
        end
        for (int c = 13; c <= 20; c++) begin
            n_cmp++; if (busy_log[c] !== 1'b0) begin
                n_bad++; $display("FAIL restart_idle[c%0d]: got busy %0d expected 0", c, busy_log[c]);
            end
        end
        do_start();
        collect(0, 14);
        n_cmp++; if (n_iss < 1 || iss_addr[0] !== 4'd0 || iss_cyc[0] !== 1) begin
            n_bad++; $display("FAIL rerun_first_issue: got addr %0d cyc %0d expected 0 at 1", iss_addr[0], iss_cyc[0]);
        end
        n_cmp++; if (n_hs !== 9 || done_cyc !== 12) begin
            n_bad++; $display("FAIL rerun_count: got %0d elems done %0d expected 9, 12", n_hs, done_cyc);
        end
        for (int i = 0; i < 9 && i < n_hs; i++) begin
            n_cmp++; if (hs_data[i] !== exp_c[i]) begin
                n_bad++; $display("FAIL rerun_elem[%0d]: got %0d expected %0d", i, hs_data[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int done_seen;
        do_start();
        collect(0, 5);
        n_cmp++; if (n_hs !== 3) begin
            n_bad++; $display("FAIL abort_delivered: got %0d expected 3", n_hs);
        end
        m_ready = 1'b1;
        rst = 1'b1;
        #1;
        n_cmp++; if ({busy, done, mem_re, m_valid, m_last} !== 5'b0 || m_data !== 16'd0 ||
                     m_index !== 4'd0 || mem_addr !== 4'd0) begin
            n_bad++; $display("FAIL abort_outputs: got flags %b data %0d idx %0d addr %0d expected 00000 0 0 0",
                              {busy, done, mem_re, m_valid, m_last}, m_data, m_index, mem_addr);
        end
        done_seen = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done || busy) done_seen++;
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done || busy || m_valid) done_seen++;
        end
        n_cmp++; if (done_seen !== 0) begin
            n_bad++; $display("FAIL abort_no_done: got %0d active cycles expected 0", done_seen);
        end
        do_start();
        collect(0, 14);
        n_cmp++; if (n_hs !== 9 || done_cyc !== 12) begin
            n_bad++; $display("FAIL abort_rerun: got %0d elems done %0d expected 9, 12", n_hs, done_cyc);
        end
        for (int i = 0; i < 9 && i < n_hs; i++) begin
            n_cmp++; if (hs_data[i] !== exp_c[i] || hs_idx[i] !== 4'(i)) begin
                n_bad++; $display("FAIL abort_elem[%0d]: got %0d idx %0d expected %0d idx %0d",
                                  i, hs_data[i], hs_idx[i], exp_c[i], i);
            end
        end
    endtask

    task automatic test_depth4();
        int k;
        int nd;
        k = 0; nd = 0;
        m_ready_4 = 1'b1;
        start_4 = 1'b1;
        tick();
        start_4 = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (m_valid_4 && m_ready_4) begin
                n_cmp++; if (k > 3 || m_data_4 !== exp_c[k & 7] || m_index_4 !== 4'(k) ||
                             m_last_4 !== (k == 3) || c !== 3 + k) begin
                    n_bad++; $display("FAIL d4_elem[%0d]: got data %0d idx %0d last %0d cyc %0d expected %0d %0d %0d %0d",
                                      k, m_data_4, m_index_4, m_last_4, c, exp_c[k & 7], k, (k == 3), 3 + k);
                end
                k++;
            end
            if (done_4) begin
                nd++;
                n_cmp++; if (c !== 7) begin
                    n_bad++; $display("FAIL d4_done_cycle: got %0d expected 7", c);
                end
            end
            tick();
        end
        n_cmp++; if (k !== 4 || nd !== 1) begin
            n_bad++; $display("FAIL d4_totals: got %0d elems %0d done expected 4, 1", k, nd);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = (i < 9) ? exp_c[i & 7 | (i & 8)] : 16'hDEAD;
        test_reset();
        test_stream();
        test_toggle_ready();
        test_stall();
        test_start_ignored();
        test_reset_midrun();
        test_depth4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
